// File: rtl/sevenseg_scan_driver.sv
//------------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Time-multiplexed driver for a common-anode 7-segment display with NDIGITS
// digits. One digit is driven per scan slot. Segments and digit selects are
// both active-low. New display values are double-buffered: a load lands in a
// pending buffer and is copied to the display buffer only when the scan wraps
// back to digit 0, so a frame is never drawn with a mix of old and new data.
//
// Parameters
//   NDIGITS       number of digits scanned (1..16)
//   DIGIT_PERIOD  clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  all-off cycles at the start of each slot (< DIGIT_PERIOD)
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous reset, active-low
//   value        in   hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp           in   decimal point per digit, active-high, captured on load
//   digit_en     in   live per-digit enable, 0 = digit dark
//   load         in   one-cycle strobe capturing value/dp
//   busy         out  pending buffer waiting to be applied
//   frame_start  out  one-cycle pulse in the cycle after the scan wraps
//   segments     out  active-low, [7:1] = a..g, [0] = dp
//   digitselect  out  active-low one-hot digit select
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digit i (i > 0) is dark if nibbles
//                          i..NDIGITS-1 are all zero and its dp is clear.
//                          The slot is still consumed; digit 0 always lit.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module sevenseg_scan_driver #(
  parameter int NDIGITS      = 8,
  parameter int DIGIT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   load,
  output logic                   busy,
  output logic                   frame_start,
  output logic [7:0]             segments,
  output logic [NDIGITS-1:0]     digitselect
);

  localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

  // Active-high segment pattern a..g (bit 6 = a, bit 0 = g). b and d are
  // lowercase glyphs so they stay distinguishable from 8 and 0.
  function automatic logic [6:0] seg_pat(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h7E;
      4'h1: pat = 7'h30;
      4'h2: pat = 7'h6D;
      4'h3: pat = 7'h79;
      4'h4: pat = 7'h33;
      4'h5: pat = 7'h5B;
      4'h6: pat = 7'h5F;
      4'h7: pat = 7'h70;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h7B;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h1F;
      4'hC: pat = 7'h4E;
      4'hD: pat = 7'h3D;
      4'hE: pat = 7'h4F;
      default: pat = 7'h47;
    endcase
    return pat;
  endfunction

  // Scan state
  logic [CW-1:0]          cnt_reg;
  logic [IW-1:0]          idx_reg;

  // Double buffer
  logic [4*NDIGITS-1:0]   pend_val_reg;
  logic [NDIGITS-1:0]     pend_dp_reg;
  logic [4*NDIGITS-1:0]   disp_val_reg;
  logic [NDIGITS-1:0]     disp_dp_reg;
  logic                   busy_reg;

  // Registered outputs
  logic                   frame_start_reg;
  logic [7:0]             segments_reg;
  logic [NDIGITS-1:0]     digitselect_reg;

  // Combinational next-output values
  logic [7:0]             segments_next;
  logic [NDIGITS-1:0]     digitselect_next;

  logic                   slot_end;
  logic                   frame_wrap;
  logic [3:0]             nib [NDIGITS];
  logic [NDIGITS-1:0]     lz_dark;

  assign slot_end   = (cnt_reg == CNT_LAST);
  assign frame_wrap = slot_end && (idx_reg == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_nib
      assign nib[gi] = disp_val_reg[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  // A set decimal point keeps the digit visible (e.g. "0.5").
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_units
        assign lz_dark[gi] = 1'b0;
      end else begin : g_upper
        assign lz_dark[gi] = (disp_val_reg[4*NDIGITS-1:4*gi] == '0)
                             && !disp_dp_reg[gi];
      end
    end
  endgenerate
`else
  assign lz_dark = '0;
`endif

  // Output decode from the current counter/index; registered below, so the
  // pins lag the scan state by one cycle. digit_en is used live here.
  always_comb begin
    logic lit;
    segments_next    = 8'hFF;
    digitselect_next = '1;
    lit = (cnt_reg >= CNT_BLANK) && digit_en[idx_reg] && !lz_dark[idx_reg];
    if (lit) begin
      segments_next    = ~{seg_pat(nib[idx_reg]), disp_dp_reg[idx_reg]};
      digitselect_next = ~(NDIGITS'(1) << idx_reg);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      pend_val_reg    <= '0;
      pend_dp_reg     <= '0;
      disp_val_reg    <= '0;
      disp_dp_reg     <= '0;
      busy_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      segments_reg    <= 8'hFF;
      digitselect_reg <= '1;
    end else begin
      // Slot counter and digit index
      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      frame_start_reg <= frame_wrap;

      // Buffer management. A load on the wrap cycle goes straight to the
      // display buffer (the new frame starts with it) and drops any older
      // pending data; otherwise loads park in pending until the next wrap.
      if (load) begin
        if (frame_wrap) begin
          disp_val_reg <= value;
          disp_dp_reg  <= dp;
          busy_reg     <= 1'b0;
        end else begin
          pend_val_reg <= value;
          pend_dp_reg  <= dp;
          busy_reg     <= 1'b1;
        end
      end else if (frame_wrap && busy_reg) begin
        disp_val_reg <= pend_val_reg;
        disp_dp_reg  <= pend_dp_reg;
        busy_reg     <= 1'b0;
      end

      segments_reg    <= segments_next;
      digitselect_reg <= digitselect_next;
    end
  end

  assign busy        = busy_reg;
  assign frame_start = frame_start_reg;
  assign segments    = segments_reg;
  assign digitselect = digitselect_reg;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
//------------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//
// Bench for sevenseg_scan_driver with NDIGITS=4, DIGIT_PERIOD=4,
// BLANK_CYCLES=1. Expected per-cycle outputs for a whole frame are pushed to
// a queue when a load is issued and popped as the display scans. Expected
// segment bytes come from the hex pattern table, written per vector.
// Honors LEADING_ZERO_BLANK_EN for the leading-zero expectations.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int DP = 4;
  localparam int BC = 1;
  localparam int FRAME = ND * DP;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    digit_en = 4'hF;
  logic          load = 1'b0;
  logic          busy;
  logic          frame_start;
  logic [7:0]    segments;
  logic [3:0]    digitselect;

  sevenseg_scan_driver #(
    .NDIGITS      (ND),
    .DIGIT_PERIOD (DP),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .dp          (dp),
    .digit_en    (digit_en),
    .load        (load),
    .busy        (busy),
    .frame_start (frame_start),
    .segments    (segments),
    .digitselect (digitselect)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [31:0] exp_seg;   // {d3,d2,d1,d0}; 8'hFF = digit dark
    string       name;
  } vec_t;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] sel;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Queue one frame's worth of expected outputs, starting with the cycle
  // after frame_start (blank cycle of digit 0).
  task automatic push_frame(input logic [31:0] segw, input logic [3:0] en);
    for (int k = 0; k < FRAME; k++) begin
      int s;
      int c;
      logic [7:0] b;
      exp_t e;
      s = k / DP;
      c = k % DP;
      b = segw[8*s +: 8];
      if (c < BC || !en[s] || b == 8'hFF) begin
        e.seg = 8'hFF;
        e.sel = 4'hF;
      end else begin
        e.seg = b;
        e.sel = ~(4'b0001 << s);
      end
      sb.push_back(e);
    end
  endtask

  // Called at the negedge of a frame_start cycle.
  task automatic check_frame(input string name);
    for (int k = 0; k < FRAME; k++) begin
      exp_t e;
      @(negedge clock);
      if (sb.size() == 0) begin
        check({name, " queue"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s seg k=%0d", name, k), segments, e.seg);
        check($sformatf("%s sel k=%0d", name, k), digitselect, e.sel);
        check($sformatf("%s fs k=%0d", name, k), frame_start, (k == FRAME - 1));
      end
    end
    $display("frame %s checked", name);
  endtask

  task automatic wait_frame_start(input string name);
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (frame_start !== 1'b1 && t < 100);
    check({name, " frame_start seen"}, frame_start, 1'b1);
  endtask

  // Returns at posedge+1 of the cycle after load was sampled.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(posedge clock);
    #1;
    value = v;
    dp    = d;
    load  = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    $display("load value=%h dp=%b", v, d);
  endtask

  logic [31:0] zero_frame;

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    zero_frame = 32'hFFFFFF03;
    vecs[3] = '{16'h0050, 4'b0000, 4'hF, 32'hFFFF4903, "lead0050"};
    vecs[7] = '{16'h0000, 4'b0100, 4'hF, 32'hFF02FF03, "zero_dp2"};
`else
    zero_frame = 32'h03030303;
    vecs[3] = '{16'h0050, 4'b0000, 4'hF, 32'h03034903, "lead0050"};
    vecs[7] = '{16'h0000, 4'b0100, 4'hF, 32'h03020303, "zero_dp2"};
`endif
    vecs[0] = '{16'h12AF, 4'b0000, 4'hF,    32'h9F251171, "12AF"};
    vecs[1] = '{16'h8888, 4'b0000, 4'b1010, 32'h01FF01FF, "en1010"};
    vecs[2] = '{16'h8888, 4'b0010, 4'b1010, 32'h01FF00FF, "en1010_dp1"};
    vecs[4] = '{16'hCDE9, 4'b1001, 4'hF,    32'h62856108, "CDE9_dp"};
    vecs[5] = '{16'h3467, 4'b0000, 4'hF,    32'h0D99411F, "3467"};
    vecs[6] = '{16'hB0F0, 4'b0000, 4'hF,    32'hC1037103, "B0F0"};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset seg", segments, 8'hFF);
    check("reset sel", digitselect, 4'hF);
    check("reset busy", busy, 1'b0);
    check("reset fs", frame_start, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post-reset blank seg", segments, 8'hFF);
    @(posedge clock); #1;
    check("post-reset d0 seg", segments, 8'h03);
    check("post-reset d0 sel", digitselect, 4'hE);
    $display("reset released, digit 0 shows zero");

    push_frame(zero_frame, 4'hF);
    wait_frame_start("initial");
    check_frame("initial");

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      digit_en = vecs[i].en;
      do_load(vecs[i].value, vecs[i].dp);
      @(negedge clock);
      check({vecs[i].name, " busy after load"}, busy, 1'b1);
      push_frame(vecs[i].exp_seg, vecs[i].en);
      wait_frame_start(vecs[i].name);
      check({vecs[i].name, " busy at frame"}, busy, 1'b0);
      check_frame(vecs[i].name);
    end
    digit_en = 4'hF;

    // Two loads in one frame: last wins
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    @(negedge clock);
    check("last-wins busy", busy, 1'b1);
    push_frame(32'h25252525, 4'hF);
    wait_frame_start("last-wins");
    check_frame("last-wins");

    // Load on the wrap cycle bypasses pending and discards older pending data.
    // At this point we sit at the negedge of the frame_start cycle C; the
    // wrap cycle is C+15.
    @(posedge clock);                 // C+1
    @(posedge clock); #1;             // C+2
    value = 16'h4444; dp = 4'b0000; load = 1'b1;
    @(posedge clock); #1;             // C+3
    load = 1'b0;
    check("bypass pending busy", busy, 1'b1);
    repeat (12) @(posedge clock);     // C+15
    #1;
    value = 16'h3333; load = 1'b1;
    @(posedge clock); #1;             // C+16
    load = 1'b0;
    $display("load value=3333 on wrap cycle");
    @(negedge clock);
    check("bypass busy", busy, 1'b0);
    check("bypass fs", frame_start, 1'b1);
    push_frame(32'h0D0D0D0D, 4'hF);
    check_frame("bypass");

    // Reset mid-frame with a pending load outstanding
    do_load(16'h5555, 4'b0000);
    @(negedge clock);
    check("pre-reset busy", busy, 1'b1);
    check("pre-reset seg", segments, 8'h0D);
    check("pre-reset sel", digitselect, 4'hE);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset seg", segments, 8'hFF);
    check("async reset sel", digitselect, 4'hF);
    check("async reset busy", busy, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    $display("mid-frame reset applied and released");
    @(posedge clock); #1;
    check("restart blank seg", segments, 8'hFF);
    @(posedge clock); #1;
    check("restart d0 seg", segments, 8'h03);
    check("restart d0 sel", digitselect, 4'hE);
    push_frame(zero_frame, 4'hF);
    wait_frame_start("after-reset");
    check("after-reset busy", busy, 1'b0);
    check_frame("after-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
